// File: rtl/plic_target_arbiter.sv
// plic_target_arbiter: per-target PLIC arbiter that scans one source per cycle and publishes the best eligible ID.
// Define PLIC_ARB_EARLY_PUBLISH_EN to end a sweep as soon as an eligible max-priority source is seen.
module plic_target_arbiter #(
  parameter  int SRC_COUNT  = 16,
  parameter  int PRIO_WIDTH = 3,
  localparam int SRC_WIDTH  = $clog2(SRC_COUNT + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SRC_COUNT-1:0]            irq_pending_i,
  input  logic [SRC_COUNT-1:0]            irq_enable_i,
  input  logic [SRC_COUNT*PRIO_WIDTH-1:0] irq_prio_i,
  input  logic [PRIO_WIDTH-1:0]           threshold_i,
  input  logic                            claim_req_i,
  output logic [SRC_WIDTH-1:0]            claim_idx_o,
  output logic                            irq_o,
  output logic                            scan_busy_o
);
  localparam int NID = 1 << SRC_WIDTH;
  localparam logic [SRC_WIDTH-1:0] LAST = SRC_WIDTH'(SRC_COUNT);
  typedef enum logic [1:0] {RESTART, SCAN, PUBLISH} state_t;
  state_t                state;
  logic [SRC_WIDTH-1:0]  cnt, best_id;
  logic [PRIO_WIDTH-1:0] best_prio;
  logic [NID-1:0]        elig;
  logic [PRIO_WIDTH-1:0] prio [NID];
  // Tables indexed directly by source ID; ID 0 and unused IDs are never eligible.
  for (genvar i = 0; i < NID; i++) begin : g_src
    if (i >= 1 && i <= SRC_COUNT) begin : g_real
      assign prio[i] = irq_prio_i[i*PRIO_WIDTH-1 -: PRIO_WIDTH];
      assign elig[i] = irq_pending_i[i-1] & irq_enable_i[i-1] & (prio[i] > threshold_i);
    end else begin : g_none
      assign prio[i] = '0;
      assign elig[i] = 1'b0;
    end
  end
  assign scan_busy_o = (state == SCAN);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESTART;
      cnt         <= '0;
      best_id     <= '0;
      best_prio   <= '0;
      claim_idx_o <= '0;
      irq_o       <= 1'b0;
    end else if (claim_req_i) begin
      state       <= RESTART;
      claim_idx_o <= '0;
      irq_o       <= 1'b0;
    end else begin
      case (state)
        RESTART: begin
          cnt       <= SRC_WIDTH'(1);
          best_id   <= '0;
          best_prio <= '0;
          state     <= SCAN;
        end
        SCAN: begin
          if (elig[cnt] && prio[cnt] > best_prio) begin
            best_id   <= cnt;
            best_prio <= prio[cnt];
          end
          cnt <= cnt + 1'b1;
`ifdef PLIC_ARB_EARLY_PUBLISH_EN
          state <= (cnt == LAST || (elig[cnt] && &prio[cnt])) ? PUBLISH : SCAN;
`else
          state <= (cnt == LAST) ? PUBLISH : SCAN;
`endif
        end
        PUBLISH: begin
          claim_idx_o <= elig[best_id] ? best_id : '0;
          irq_o       <= elig[best_id];
          state       <= RESTART;
        end
        default: state <= RESTART;
      endcase
    end
  end
endmodule

// File: tb/tb_plic_target_arbiter.sv
// tb_plic_target_arbiter: randomized and directed checks against a snapshot winner model.
module tb_plic_target_arbiter;
  localparam int SC = 16;
  localparam int PW = 3;
  localparam int SW = $clog2(SC + 1);
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SC-1:0] pend = '0, en = '0;
  logic [SC*PW-1:0] prio = '0;
  logic [PW-1:0] thr = '0;
  logic          claim = 1'b0;
  logic [SW-1:0] claim_idx;
  logic          irq, busy;
  int checks = 0, errors = 0;
  int exp_id, lat, held;
  plic_target_arbiter #(.SRC_COUNT(SC), .PRIO_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .irq_pending_i(pend), .irq_enable_i(en), .irq_prio_i(prio),
    .threshold_i(thr), .claim_req_i(claim), .claim_idx_o(claim_idx), .irq_o(irq), .scan_busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic int src_prio(input int n);
    logic [SC*PW-1:0] t;
    t = prio >> ((n - 1) * PW);
    return int'(t[PW-1:0]);
  endfunction
  function automatic bit eligible(input int n);
    return pend[n-1] && en[n-1] && src_prio(n) > int'(thr);
  endfunction
  // Winner: highest eligible priority, lowest ID among equals; 0 when nothing is eligible.
  function automatic int winner();
    int top = 0;
    for (int n = 1; n <= SC; n++) if (eligible(n) && src_prio(n) > top) top = src_prio(n);
    if (top == 0) return 0;
    for (int n = 1; n <= SC; n++) if (eligible(n) && src_prio(n) == top) return n;
    return 0;
  endfunction
  // Edges from a RESTART cycle until the published value is visible.
  function automatic int latency();
`ifdef PLIC_ARB_EARLY_PUBLISH_EN
    for (int n = 1; n <= SC; n++) if (eligible(n) && src_prio(n) == (1 << PW) - 1) return n + 2;
`endif
    return SC + 2;
  endfunction
  task automatic set_prio(input int n, input int p);
    prio[n*PW-1 -: PW] = PW'(p);
  endtask
  task automatic expect_out(input string tag, input int id);
    check({tag, "_id"}, int'(claim_idx), id);
    check({tag, "_irq"}, int'(irq), int'(id != 0));
  endtask
  task automatic claim_pulse();
    claim = 1'b1;
    cyc(1);
    claim = 1'b0;
  endtask
  // Abort any sweep, then watch one full sweep with inputs held.
  task automatic run_case(input string tag);
    exp_id = winner();
    lat = latency();
    claim_pulse();
    expect_out({tag, "_clr"}, 0);
    check({tag, "_restart"}, int'(busy), 0);
    cyc(1);
    check({tag, "_busy"}, int'(busy), 1);
    cyc(lat - 2);
    expect_out({tag, "_pre"}, 0);
    cyc(1);
    expect_out(tag, exp_id);
  endtask
  task automatic clear_all();
    pend = '0; en = '0; prio = '0; thr = '0;
  endtask
  initial begin
    #2;
    expect_out("reset", 0);
    check("reset_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // single source, then hold until claim
    pend[2] = 1; en[2] = 1; set_prio(3, 2);
    run_case("t1");
    cyc(25);
    expect_out("t1_hold", 3);
    claim_pulse();
    expect_out("t1_claim", 0);
    // priority tie resolved by lowest ID
    clear_all();
    pend[1] = 1; pend[8] = 1; pend[3] = 1; en = '1; thr = 1;
    set_prio(2, 5); set_prio(9, 5); set_prio(4, 3);
    run_case("t2");
    pend[1] = 0;
    run_case("t2_drop");
    // threshold boundary: equal is not enough
    clear_all();
    pend[4] = 1; en[4] = 1; set_prio(5, 4); thr = 4;
    run_case("t3_eq");
    thr = 3;
    run_case("t3");
    // pending dropped after publish is held until the next publish
    clear_all();
    pend[6] = 1; en[6] = 1; set_prio(7, 6);
    run_case("t4");
    pend[6] = 0;
    cyc(1);
    expect_out("t4_hold", 7);
    cyc(latency() - 1);
    expect_out("t4_retract", 0);
    // claim on the PUBLISH cycle suppresses the publish
    pend[6] = 1;
    claim_pulse();
    cyc(latency() - 1);
    claim_pulse();
    expect_out("t5_claim", 0);
    cyc(latency() - 1);
    expect_out("t5_nostale", 0);
    cyc(1);
    expect_out("t5_next", 7);
    // max priority on source 1
    clear_all();
    pend[0] = 1; en[0] = 1; set_prio(1, 7); pend[5] = 1; en[5] = 1; set_prio(6, 7);
    run_case("t6");
    // async reset mid-sweep
    clear_all();
    pend[10] = 1; en[10] = 1; set_prio(11, 3);
    claim_pulse();
    cyc(5);
    rst = 1'b1;
    #1;
    expect_out("areset", 0);
    check("areset_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    held = latency();
    cyc(held - 1);
    expect_out("areset_pre", 0);
    cyc(1);
    expect_out("areset_pub", 11);
    // randomized snapshots
    for (int t = 0; t < 30; t++) begin
      pend = SC'($urandom);
      en = SC'($urandom | $urandom);
      prio = (SC*PW)'({$urandom, $urandom});
      thr = PW'($urandom_range(0, 4));
      run_case($sformatf("rnd%0d", t));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
